// File: rtl/alu_cu.sv
// 32-bit ALU with its ALU-control decoder. Operands are decoded and evaluated
// combinationally, and result plus flags are registered one clock after sampling.
module alu_cu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       funct,
    input  logic [1:0]       aluop,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_NONE
    } op_e;

    op_e              op;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [SHW-1:0]   shamt;
    logic             slt_s;
    logic             slt_u;
    logic [WIDTH-1:0] res_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;

    // Control decode: aluop selects a fixed class, or defers to funct.
    always_comb begin
        op = OP_NONE;
        case (aluop)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b11: op = OP_OR;
            default: begin
                case (funct)
                    4'b0000: op = OP_ADD;
                    4'b0010: op = OP_SUB;
                    4'b0100: op = OP_AND;
                    4'b0101: op = OP_OR;
                    4'b0110: op = OP_XOR;
                    4'b0111: op = OP_NOR;
                    4'b1000: op = OP_SLL;
                    4'b1001: op = OP_SRL;
                    4'b1100: op = OP_SRA;
                    4'b1010: op = OP_SLT;
                    4'b1011: op = OP_SLTU;
                    default: op = OP_NONE;
                endcase
            end
        endcase
    end

    // Subtract as a + ~b + 1 so carry-out reads as "no borrow".
    assign add_sum = {1'b0, a} + {1'b0, b};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt   = b[SHW-1:0];
    assign slt_s   = $signed(a) < $signed(b);
    assign slt_u   = a < b;

    always_comb begin
        res_d  = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        case (op)
            OP_ADD: begin
                res_d  = add_sum[WIDTH-1:0];
                cout_d = add_sum[WIDTH];
                ovf_d  = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_d  = sub_sum[WIDTH-1:0];
                cout_d = sub_sum[WIDTH];
                ovf_d  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            OP_XOR:  res_d = a ^ b;
            OP_NOR:  res_d = ~(a | b);
            OP_SLL:  res_d = a << shamt;
            OP_SRL:  res_d = a >> shamt;
            OP_SRA:  res_d = $signed(a) >>> shamt;
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, slt_s};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, slt_u};
            default: res_d = '0;
        endcase
    end

    assign zero_d = (res_d == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            result   <= '0;
            cout     <= 1'b0;
            zero     <= 1'b1;
            overflow <= 1'b0;
        end else begin
            result   <= res_d;
            cout     <= cout_d;
            zero     <= zero_d;
            overflow <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_cu.sv
// Bench for alu_cu: directed boundary cases then random operations, each
// compared one cycle later against an arithmetic reference model.
module tb_alu_cu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  funct;
    logic [1:0]  aluop;
    logic [31:0] result;
    logic        cout;
    logic        zero;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    // Expected entry packs {result, cout, zero, overflow}.
    logic [34:0] exp_q[$];

    alu_cu #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .funct    (funct),
        .aluop    (aluop),
        .result   (result),
        .cout     (cout),
        .zero     (zero),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on 64-bit values.
    function automatic logic [34:0] model(input logic r, input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] f, input logic [1:0] op);
        string       kind;
        longint      sx;
        longint      sy;
        longint      s;
        longint unsigned u;
        logic [31:0] res;
        logic        c;
        logic        v;
        int          sh;
        if (r) return {32'h0, 1'b0, 1'b1, 1'b0};
        sx  = $signed(x);
        sy  = $signed(y);
        sh  = int'(y % 32);
        res = 32'h0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            2'd0: kind = "add";
            2'd1: kind = "sub";
            2'd3: kind = "or";
            default: begin
                case (f)
                    4'd0:  kind = "add";
                    4'd2:  kind = "sub";
                    4'd4:  kind = "and";
                    4'd5:  kind = "or";
                    4'd6:  kind = "xor";
                    4'd7:  kind = "nor";
                    4'd8:  kind = "sll";
                    4'd9:  kind = "srl";
                    4'd12: kind = "sra";
                    4'd10: kind = "slt";
                    4'd11: kind = "sltu";
                    default: kind = "none";
                endcase
            end
        endcase
        case (kind)
            "add": begin
                u   = longint'(x) + longint'(y);
                res = u[31:0];
                c   = u >= 64'h1_0000_0000;
                s   = sx + sy;
                v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            "sub": begin
                res = x - y;
                c   = x >= y;
                s   = sx - sy;
                v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            "and":  res = x & y;
            "or":   res = x | y;
            "xor":  res = x ^ y;
            "nor":  res = ~(x | y);
            "sll":  res = x << sh;
            "srl":  res = x >> sh;
            "sra":  begin s = sx >>> sh; res = s[31:0]; end
            "slt":  res = (sx < sy) ? 32'd1 : 32'd0;
            "sltu": res = (x < y) ? 32'd1 : 32'd0;
            default: res = 32'h0;
        endcase
        return {res, c, (res == 32'h0), v};
    endfunction

    task automatic drive(input logic r, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] f, input logic [1:0] op);
        reset = r;
        a     = x;
        b     = y;
        funct = f;
        aluop = op;
        exp_q.push_back(model(r, x, y, f, op));
    endtask

    // Advance one edge and compare the output against the oldest expectation.
    task automatic step();
        logic [34:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("result",   result,          e[34:3]);
            check("cout",     {31'h0, cout},     {31'h0, e[2]});
            check("zero",     {31'h0, zero},     {31'h0, e[1]});
            check("overflow", {31'h0, overflow}, {31'h0, e[0]});
        end
    endtask

    task automatic op_step(input logic [31:0] x, input logic [31:0] y,
                           input logic [3:0] f, input logic [1:0] op);
        drive(1'b0, x, y, f, op);
        step();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        a     = '0;
        b     = '0;
        funct = '0;
        aluop = '0;

        // Reset held two cycles with random operands.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            step();
        end

        op_step(32'h15, 32'h15, 4'h0, 2'b00);
        op_step(32'hFFFF_FFFF, 32'h1, 4'h0, 2'b00);
        op_step(32'h7FFF_FFFF, 32'h1, 4'h0, 2'b00);
        op_step(32'h15, 32'h15, 4'h0, 2'b01);
        op_step(32'h8000_0000, 32'h1, 4'h0, 2'b01);
        op_step(32'h1, 32'h2, 4'h0, 2'b01);
        op_step(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0100, 2'b10);
        op_step(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0101, 2'b10);
        op_step(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0110, 2'b10);
        op_step(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0111, 2'b10);
        op_step(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 2'b11);
        op_step(32'h1, 32'h1F, 4'b1000, 2'b10);
        op_step(32'h8000_0000, 32'h4, 4'b1100, 2'b10);
        op_step(32'h8000_0000, 32'h4, 4'b1001, 2'b10);
        op_step(32'h8000_0000, 32'hFFFF_FFE0, 4'b1100, 2'b10);
        op_step(32'hFFFF_FFFF, 32'h1, 4'b1010, 2'b10);
        op_step(32'hFFFF_FFFF, 32'h1, 4'b1011, 2'b10);
        op_step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111, 2'b10);
        op_step(32'h1234_5678, 32'h1, 4'b0001, 2'b10);

        // Mid-stream reset pulse, then back-to-back random traffic.
        drive(1'b1, 32'hFFFF_FFFF, 32'h1, 4'h0, 2'b00);
        step();
        for (int i = 0; i < 400; i++) begin
            op_step(rand_operand(), rand_operand(), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
